// File: rtl/ntt_ctrl.sv
// NTT/INTT address-generation controller.
// Sequences seven butterfly layers over a 256-entry coefficient RAM, issuing one
// butterfly read per cycle and replaying its addresses LAT cycles later as the
// write-back strobe. Coefficient data never passes through this block.
module ntt_ctrl #(
  parameter int unsigned N      = 256,
  parameter int unsigned LAYERS = 7,
  parameter int unsigned LAT    = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_intt,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_bfu_intt,
  output logic                   o_rd_en,
  output logic [$clog2(N)-1:0]   o_rd_addr_a,
  output logic [$clog2(N)-1:0]   o_rd_addr_b,
  output logic [$clog2(N)-2:0]   o_zeta_idx,
  output logic                   o_wr_en,
  output logic [$clog2(N)-1:0]   o_wr_addr_a,
  output logic [$clog2(N)-1:0]   o_wr_addr_b
);

  localparam int unsigned AW = $clog2(N);       // coefficient address width
  localparam int unsigned BW = AW - 1;          // butterfly index / zeta width
  localparam int unsigned LW = $clog2(LAYERS);  // layer counter width
  localparam int unsigned SW = LW + 1;          // log2(len) width
  localparam int unsigned DW = $clog2(LAT + 1); // drain counter width

  localparam logic [SW-1:0] ShOne     = SW'(1);
  localparam logic [SW-1:0] ShTop     = SW'(BW);
  localparam logic [AW-1:0] AddrOne   = AW'(1);
  localparam logic [BW-1:0] BfLast    = BW'(N / 2 - 1);
  localparam logic [BW-1:0] HalfM1    = BW'(N / 2 - 1);
  localparam logic [BW-1:0] QuarterN  = BW'(N / 4);
  localparam logic [LW-1:0] LayLast   = LW'(LAYERS - 1);
  localparam logic [DW-1:0] DrainLast = DW'(LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   bfly_q, bfly_d;
  logic [LW-1:0]   layer_q, layer_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            intt_q, intt_d;
  logic            issue;

  logic [SW-1:0]   sh;     // log2 of the current butterfly span
  logic [AW-1:0]   len;
  logic [BW-1:0]   grp;
  logic [BW-1:0]   off;
  logic [AW-1:0]   addr_a;
  logic [AW-1:0]   addr_b;
  logic [BW-1:0]   zeta;

  logic [LAT-1:0]  wr_vld_q;
  logic [AW-1:0]   wr_a_q [LAT];
  logic [AW-1:0]   wr_b_q [LAT];

  // State, counters and latched direction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      bfly_q  <= '0;
      layer_q <= '0;
      drain_q <= '0;
      intt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bfly_q  <= bfly_d;
      layer_q <= layer_d;
      drain_q <= drain_d;
      intt_q  <= intt_d;
    end
  end

  // Layer/butterfly sequencing; DRAIN lets the last writes land before the next layer reads.
  always_comb begin
    state_d = state_q;
    bfly_d  = bfly_q;
    layer_d = layer_q;
    drain_d = drain_q;
    intt_d  = intt_q;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StIssue;
          bfly_d  = '0;
          layer_d = '0;
          intt_d  = i_intt;
        end
      end
      StIssue: begin
        issue = 1'b1;
        if (bfly_q == BfLast) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          bfly_d = bfly_q + BW'(1);
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          bfly_d = '0;
          if (layer_q == LayLast) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
            layer_d = layer_q + LW'(1);
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Butterfly address and twiddle index for the current issue slot.
  always_comb begin
    sh     = intt_q ? ({1'b0, layer_q} + ShOne) : (ShTop - {1'b0, layer_q});
    len    = AddrOne << sh;
    grp    = bfly_q >> sh;
    off    = bfly_q & BW'(len - AddrOne);
    addr_a = (AW'(grp) << (sh + ShOne)) | AW'(off);
    addr_b = addr_a + len;
    // 127 >> (sh-1) equals 256/len - 1; 64 >> (sh-1) equals 128/len.
    zeta   = intt_q ? ((HalfM1 >> (sh - ShOne)) - grp) : ((QuarterN >> (sh - ShOne)) + grp);
  end

  // Write-back address pipeline mirrors the read-to-writeback latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        wr_a_q[i] <= '0;
        wr_b_q[i] <= '0;
      end
    end else begin
      wr_vld_q[0] <= issue;
      wr_a_q[0]   <= issue ? addr_a : '0;
      wr_b_q[0]   <= issue ? addr_b : '0;
      for (int i = 1; i < LAT; i++) begin
        wr_vld_q[i] <= wr_vld_q[i-1];
        wr_a_q[i]   <= wr_a_q[i-1];
        wr_b_q[i]   <= wr_b_q[i-1];
      end
    end
  end

  // Output decode; addresses are forced to zero whenever their strobe is low.
  always_comb begin
    o_busy      = (state_q != StIdle);
    o_done      = (state_q == StDone);
    o_bfu_intt  = intt_q;
    o_rd_en     = issue;
    o_rd_addr_a = issue ? addr_a : '0;
    o_rd_addr_b = issue ? addr_b : '0;
    o_zeta_idx  = issue ? zeta : '0;
    o_wr_en     = wr_vld_q[LAT-1];
    o_wr_addr_a = wr_vld_q[LAT-1] ? wr_a_q[LAT-1] : '0;
    o_wr_addr_b = wr_vld_q[LAT-1] ? wr_b_q[LAT-1] : '0;
  end

endmodule
